// File: rtl/ysyx_24100006_hazard_ctrl_pkg.sv
// Shared constants and fence.i FSM encoding for the pipeline hazard controller.
package ysyx_24100006_hazard_ctrl_pkg;

   localparam int unsigned HC_NREG  = 16;   // RV32E architectural GPRs
   localparam int unsigned HC_CNT_W = 2;    // up to 3 in-flight writers per register
   localparam int unsigned HC_AW    = 4;    // GPR address width
   localparam int unsigned HC_XLEN  = 32;

   typedef enum logic [1:0] {
      HC_IDLE    = 2'd0,
      HC_DRAIN   = 2'd1,
      HC_ICFLUSH = 2'd2,
      HC_REFETCH = 2'd3
   } hc_state_e;

endpackage

// File: rtl/ysyx_24100006_scoreboard.sv
// Per-GPR in-flight writer counters; x0 is never tracked and counters saturate.
module ysyx_24100006_scoreboard #(
   parameter int unsigned NREG  = 16,
   parameter int unsigned CNT_W = 2,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic [AW-1:0]    inc_addr_i,
   input  logic             dec_i,
   input  logic [AW-1:0]    dec_addr_i,
   input  logic [AW-1:0]    rd_a_addr_i,
   input  logic [AW-1:0]    rd_b_addr_i,
   output logic [CNT_W-1:0] rd_a_cnt_o,
   output logic [CNT_W-1:0] rd_b_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [NREG-1:0]  inc_vec;
   logic [NREG-1:0]  dec_vec;

   // One-hot register selects; address 0 never hits.
   assign inc_vec = (inc_i && inc_addr_i != '0) ? (NREG'(1) << inc_addr_i) : '0;
   assign dec_vec = (dec_i && dec_addr_i != '0) ? (NREG'(1) << dec_addr_i) : '0;

   // Next counts: inc and dec on the same register cancel; no wrap at either end.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         case ({inc_vec[r], dec_vec[r]})
            2'b10:   if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_W'(1);
            2'b01:   if (cnt_q[r] != '0)      cnt_d[r] = cnt_q[r] - CNT_W'(1);
            default: cnt_d[r] = cnt_q[r];
         endcase
      end
   end

   // Counter array register.
   always_ff @(posedge clk) begin
      for (int unsigned r = 0; r < NREG; r++) begin
         if (reset) cnt_q[r] <= '0;
         else       cnt_q[r] <= cnt_d[r];
      end
   end

   assign rd_a_cnt_o = cnt_q[rd_a_addr_i];
   assign rd_b_cnt_o = cnt_q[rd_b_addr_i];

   // A fourth in-flight writer or a retire with nothing in flight is an upstream bug.
   for (genvar g = 1; g < NREG; g++) begin : g_chk
      a_no_overflow: assert property (@(posedge clk) disable iff (reset)
         !(inc_vec[g] && !dec_vec[g] && cnt_q[g] == CNT_MAX));
      a_no_underflow: assert property (@(posedge clk) disable iff (reset)
         !(dec_vec[g] && !inc_vec[g] && cnt_q[g] == '0));
   end

endmodule

// File: rtl/ysyx_24100006_hazard_ctrl.sv
// Pipeline stall/flush control: RAW scoreboard interlock, EXE redirect, fence.i sequencing.
module ysyx_24100006_hazard_ctrl
   import ysyx_24100006_hazard_ctrl_pkg::*;
#(
   parameter int unsigned NREG  = HC_NREG,
   parameter int unsigned CNT_W = HC_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [HC_AW-1:0]   id_rs1,
   input  logic [HC_AW-1:0]   id_rs2,
   input  logic               id_rs1_used,
   input  logic               id_rs2_used,
   input  logic [HC_AW-1:0]   id_rd,
   input  logic               id_gpr_write,
   input  logic               id_fire,
   input  logic               wb_fire,
   input  logic               wb_gpr_write,
   input  logic [HC_AW-1:0]   wb_rd,
   input  logic               exe_redirect,
   input  logic [HC_XLEN-1:0] exe_redirect_pc,
   input  logic               exe_fence_i,
   input  logic [HC_XLEN-1:0] exe_pc_add_4,
   input  logic               pipe_empty,
   input  logic               icache_flush_done,
   output logic               id_stall,
   output logic               flush,
   output logic               pc_redirect_valid,
   output logic [HC_XLEN-1:0] pc_redirect,
   output logic               icache_flush_req,
   output logic               fence_busy
);

   hc_state_e          state_q, state_d;
   logic [HC_XLEN-1:0] fence_pc_q, fence_pc_d;
   logic [CNT_W-1:0]   rs1_cnt, rs2_cnt;
   logic               raw_hazard;

   ysyx_24100006_scoreboard #(
      .NREG  (NREG),
      .CNT_W (CNT_W),
      .AW    (HC_AW)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .inc_i       (id_fire && id_gpr_write),
      .inc_addr_i  (id_rd),
      .dec_i       (wb_fire && wb_gpr_write),
      .dec_addr_i  (wb_rd),
      .rd_a_addr_i (id_rs1),
      .rd_b_addr_i (id_rs2),
      .rd_a_cnt_o  (rs1_cnt),
      .rd_b_cnt_o  (rs2_cnt)
   );

   // RAW interlock: any in-flight writer of a used source holds IDU (no bypass network).
   always_comb begin
      raw_hazard = id_valid &&
                   ((id_rs1_used && id_rs1 != '0 && rs1_cnt != '0) ||
                    (id_rs2_used && id_rs2 != '0 && rs2_cnt != '0));
   end

   // fence.i state and return-PC register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HC_IDLE;
         fence_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         fence_pc_q <= fence_pc_d;
      end
   end

   // fence.i next state; a redirect in the same cycle squashes the fence.
   always_comb begin
      state_d    = state_q;
      fence_pc_d = fence_pc_q;
      unique case (state_q)
         HC_IDLE: begin
            if (exe_fence_i && !exe_redirect) begin
               state_d    = HC_DRAIN;
               fence_pc_d = exe_pc_add_4;
            end
         end
         HC_DRAIN:   if (pipe_empty)        state_d = HC_ICFLUSH;
         HC_ICFLUSH: if (icache_flush_done) state_d = HC_REFETCH;
         HC_REFETCH: state_d = HC_IDLE;
         default:    state_d = HC_IDLE;
      endcase
   end

   // Outputs; forced low during reset so an in-progress fence drops its request at once.
   // An EXE redirect outside IDLE is illegal and is ignored here.
   always_comb begin
      id_stall          = 1'b0;
      flush             = 1'b0;
      pc_redirect_valid = 1'b0;
      pc_redirect       = '0;
      icache_flush_req  = 1'b0;
      fence_busy        = 1'b0;
      if (!reset) begin
         unique case (state_q)
            HC_IDLE: begin
               if (exe_redirect) begin
                  flush             = 1'b1;
                  pc_redirect_valid = 1'b1;
                  pc_redirect       = exe_redirect_pc;
               end
            end
            HC_DRAIN:   fence_busy = 1'b1;
            HC_ICFLUSH: begin
               fence_busy       = 1'b1;
               icache_flush_req = 1'b1;
            end
            HC_REFETCH: begin
               fence_busy        = 1'b1;
               flush             = 1'b1;
               pc_redirect_valid = 1'b1;
               pc_redirect       = fence_pc_q;
            end
            default: fence_busy = 1'b0;
         endcase
         id_stall = raw_hazard || flush || fence_busy;
      end
   end

   a_redirect_idle: assert property (@(posedge clk) disable iff (reset)
      !(exe_redirect && state_q != HC_IDLE));

endmodule

// File: tb/tb_ysyx_24100006_hazard_ctrl.sv
// Bench for the hazard controller: directed table, fence.i sequences, random vs reference model.
module tb_ysyx_24100006_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_rs1_used, id_rs2_used, id_gpr_write, id_fire;
   logic [3:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        wb_fire, wb_gpr_write, exe_redirect, exe_fence_i, pipe_empty, icache_flush_done;
   logic [31:0] exe_redirect_pc, exe_pc_add_4;
   logic        id_stall, flush, pc_redirect_valid, icache_flush_req, fence_busy;
   logic [31:0] pc_redirect;

   always #5 clk = ~clk;

   ysyx_24100006_hazard_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .id_valid          (id_valid),
      .id_rs1            (id_rs1),
      .id_rs2            (id_rs2),
      .id_rs1_used       (id_rs1_used),
      .id_rs2_used       (id_rs2_used),
      .id_rd             (id_rd),
      .id_gpr_write      (id_gpr_write),
      .id_fire           (id_fire),
      .wb_fire           (wb_fire),
      .wb_gpr_write      (wb_gpr_write),
      .wb_rd             (wb_rd),
      .exe_redirect      (exe_redirect),
      .exe_redirect_pc   (exe_redirect_pc),
      .exe_fence_i       (exe_fence_i),
      .exe_pc_add_4      (exe_pc_add_4),
      .pipe_empty        (pipe_empty),
      .icache_flush_done (icache_flush_done),
      .id_stall          (id_stall),
      .flush             (flush),
      .pc_redirect_valid (pc_redirect_valid),
      .pc_redirect       (pc_redirect),
      .icache_flush_req  (icache_flush_req),
      .fence_busy        (fence_busy)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: in-flight writer count per register, fence phase, saved return PC.
   int unsigned m_cnt [16];
   int unsigned m_phase;   // 0 idle, 1 drain, 2 icache flush, 3 refetch
   int unsigned m_fpc;

   typedef struct {
      string name;
      int unsigned rst, idv, rs1, u1, rs2, u2, rd, gw, idf, wbf, wbw, wbrd, redir, rpc, fence, pc4, pe, done;
      int unsigned s, f, p, pc, ic, b;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic quiet();
      reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0;
      id_rd = '0; id_gpr_write = 1'b0; id_fire = 1'b0; wb_fire = 1'b0; wb_gpr_write = 1'b0; wb_rd = '0;
      exe_redirect = 1'b0; exe_redirect_pc = '0; exe_fence_i = 1'b0; exe_pc_add_4 = '0;
      pipe_empty = 1'b0; icache_flush_done = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      reset = 1'(v.rst); id_valid = 1'(v.idv); id_rs1 = 4'(v.rs1); id_rs1_used = 1'(v.u1);
      id_rs2 = 4'(v.rs2); id_rs2_used = 1'(v.u2); id_rd = 4'(v.rd); id_gpr_write = 1'(v.gw);
      id_fire = 1'(v.idf); wb_fire = 1'(v.wbf); wb_gpr_write = 1'(v.wbw); wb_rd = 4'(v.wbrd);
      exe_redirect = 1'(v.redir); exe_redirect_pc = v.rpc; exe_fence_i = 1'(v.fence);
      exe_pc_add_4 = v.pc4; pipe_empty = 1'(v.pe); icache_flush_done = 1'(v.done);
   endtask

   task automatic check_outs(input string tag, input int unsigned s, f, p, pc, ic, b);
      chk({tag, ".id_stall"},          32'(id_stall),          s);
      chk({tag, ".flush"},             32'(flush),             f);
      chk({tag, ".pc_redirect_valid"}, 32'(pc_redirect_valid), p);
      chk({tag, ".pc_redirect"},       pc_redirect,            pc);
      chk({tag, ".icache_flush_req"},  32'(icache_flush_req),  ic);
      chk({tag, ".fence_busy"},        32'(fence_busy),        b);
   endtask

   // Expected outputs from the model state and the inputs currently driven.
   function automatic void m_expect(output int unsigned s, f, p, pc, ic, b);
      bit hz, redir_now;
      s = 0; f = 0; p = 0; pc = 0; ic = 0; b = 0;
      if (reset) return;
      hz = id_valid && ((id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] != 0) ||
                        (id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] != 0));
      redir_now = (m_phase == 0) && exe_redirect;
      if (redir_now)    begin f = 1; p = 1; pc = exe_redirect_pc; end
      if (m_phase == 3) begin f = 1; p = 1; pc = m_fpc; end
      ic = (m_phase == 2) ? 1 : 0;
      b  = (m_phase != 0) ? 1 : 0;
      s  = (hz || f != 0 || b != 0) ? 1 : 0;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_update();
      int inc_r, dec_r;
      if (reset) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_phase = 0;
         m_fpc   = 0;
         return;
      end
      inc_r = (id_fire && id_gpr_write && id_rd != 0) ? int'(id_rd) : -1;
      dec_r = (wb_fire && wb_gpr_write && wb_rd != 0) ? int'(wb_rd) : -1;
      if (inc_r != dec_r) begin
         if (inc_r >= 0 && m_cnt[inc_r] < 3) m_cnt[inc_r]++;
         if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
      end
      case (m_phase)
         0: if (exe_fence_i && !exe_redirect) begin m_phase = 1; m_fpc = exe_pc_add_4; end
         1: if (pipe_empty) m_phase = 2;
         2: if (icache_flush_done) m_phase = 3;
         default: m_phase = 0;
      endcase
   endtask

   task automatic step_exp(input string tag, input int unsigned s, f, p, pc, ic, b);
      #1;
      check_outs(tag, s, f, p, pc, ic, b);
      model_update();
      @(negedge clk);
   endtask

   vec_t tbl [$];

   initial begin
      int unsigned es, ef, ep, epc, eic, eb;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_phase = 0;
      m_fpc   = 0;
      quiet();
      reset = 1'b1;

      //            name          rst idv rs1 u1 rs2 u2 rd gw idf wbf wbw wbrd rdr rpc           fnc pc4     pe dn   s f p pc            ic b
      tbl.push_back('{"reset",      1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"wr_x5",      0, 1, 0, 0, 0, 0, 5, 1, 1,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"raw_x5",     0, 1, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  1,0,0,0,            0,0});
      tbl.push_back('{"raw_x5_wb",  0, 1, 5, 1, 0, 0, 0, 0, 0,  1, 1, 5,  0, 0,            0, 0,       0, 0,  1,0,0,0,            0,0});
      tbl.push_back('{"x5_free",    0, 1, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"wr_x0",      0, 1, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"rd_x0",      0, 1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"wr_x3",      0, 1, 0, 0, 0, 0, 3, 1, 1,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"x3_inc_dec", 0, 1, 0, 0, 0, 0, 3, 1, 1,  1, 1, 3,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"raw_x3",     0, 1, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  1,0,0,0,            0,0});
      tbl.push_back('{"raw_x3_wb",  0, 1, 0, 0, 3, 1, 0, 0, 0,  1, 1, 3,  0, 0,            0, 0,       0, 0,  1,0,0,0,            0,0});
      tbl.push_back('{"x3_free",    0, 1, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});
      tbl.push_back('{"redirect",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 32'h30000100, 0, 0,       0, 0,  1,1,1,32'h30000100, 0,0});
      tbl.push_back('{"redir_fnc",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 32'h30000200, 1, 32'h1234, 1, 1,  1,1,1,32'h30000200, 0,0});
      tbl.push_back('{"post_redir", 0, 1, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0,  0, 0,            0, 0,       0, 0,  0,0,0,0,            0,0});

      @(negedge clk);
      foreach (tbl[i]) begin
         apply(tbl[i]);
         step_exp(tbl[i].name, tbl[i].s, tbl[i].f, tbl[i].p, tbl[i].pc, tbl[i].ic, tbl[i].b);
      end

      // fence.i with a slow drain and a slow I-cache flush.
      quiet(); exe_fence_i = 1'b1; exe_pc_add_4 = 32'h30000044;
      step_exp("fence_issue", 0, 0, 0, 0, 0, 0);
      quiet(); step_exp("drain1", 1, 0, 0, 0, 0, 1);
      quiet(); step_exp("drain2", 1, 0, 0, 0, 0, 1);
      quiet(); pipe_empty = 1'b1; step_exp("drain3", 1, 0, 0, 0, 0, 1);
      for (int k = 1; k <= 4; k++) begin
         quiet(); icache_flush_done = (k == 4);
         step_exp($sformatf("icflush%0d", k), 1, 0, 0, 0, 1, 1);
      end
      quiet(); step_exp("refetch", 1, 1, 1, 32'h30000044, 0, 1);
      quiet(); step_exp("fence_done", 0, 0, 0, 0, 0, 0);

      // Minimum-latency fence.i: three busy cycles.
      quiet(); exe_fence_i = 1'b1; exe_pc_add_4 = 32'h00001008; pipe_empty = 1'b1; icache_flush_done = 1'b1;
      step_exp("fast_issue", 0, 0, 0, 0, 0, 0);
      quiet(); pipe_empty = 1'b1; icache_flush_done = 1'b1;
      step_exp("fast_drain", 1, 0, 0, 0, 0, 1);
      quiet(); pipe_empty = 1'b1; icache_flush_done = 1'b1;
      step_exp("fast_icflush", 1, 0, 0, 0, 1, 1);
      quiet(); pipe_empty = 1'b1; icache_flush_done = 1'b1;
      step_exp("fast_refetch", 1, 1, 1, 32'h00001008, 0, 1);
      quiet(); step_exp("fast_idle", 0, 0, 0, 0, 0, 0);

      // Reset during ICFLUSH; also clears a pending x7 writer.
      quiet(); exe_fence_i = 1'b1; exe_pc_add_4 = 32'h40000000;
      id_valid = 1'b1; id_rd = 4'd7; id_gpr_write = 1'b1; id_fire = 1'b1;
      step_exp("rst_issue", 0, 0, 0, 0, 0, 0);
      quiet(); pipe_empty = 1'b1; step_exp("rst_drain", 1, 0, 0, 0, 0, 1);
      quiet(); step_exp("rst_icflush", 1, 0, 0, 0, 1, 1);
      quiet(); reset = 1'b1; step_exp("rst_during_icflush", 0, 0, 0, 0, 0, 0);
      quiet(); id_valid = 1'b1; id_rs1 = 4'd7; id_rs1_used = 1'b1;
      step_exp("after_reset", 0, 0, 0, 0, 0, 0);

      // Random traffic against the reference model, keeping the environment legal.
      for (int n = 0; n < 3000; n++) begin
         quiet();
         reset        = ($urandom_range(0, 199) == 0);
         id_valid     = 1'($urandom_range(0, 1));
         id_rs1       = 4'($urandom_range(0, 15));
         id_rs2       = 4'($urandom_range(0, 15));
         id_rs1_used  = 1'($urandom_range(0, 1));
         id_rs2_used  = 1'($urandom_range(0, 1));
         id_rd        = 4'($urandom_range(0, 15));
         id_gpr_write = ($urandom_range(0, 3) != 0) && (m_cnt[id_rd] < 3);
         wb_rd        = 4'($urandom_range(0, 15));
         wb_fire      = 1'($urandom_range(0, 1));
         wb_gpr_write = ($urandom_range(0, 3) != 0) && (m_cnt[wb_rd] != 0);
         exe_redirect = (m_phase == 0) && ($urandom_range(0, 9) == 0);
         exe_redirect_pc   = $urandom;
         exe_fence_i       = ($urandom_range(0, 14) == 0);
         exe_pc_add_4      = $urandom;
         pipe_empty        = 1'($urandom_range(0, 1));
         icache_flush_done = ($urandom_range(0, 3) == 0);
         m_expect(es, ef, ep, epc, eic, eb);
         id_fire = id_valid && (es == 0) && ($urandom_range(0, 3) != 0);
         m_expect(es, ef, ep, epc, eic, eb);
         step_exp($sformatf("rand%0d", n), es, ef, ep, epc, eic, eb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
